// File: rtl/rnn_cell_param.sv
// Parametrised RNN cell: h_t = act(W.x_t + b_x + U.h_{t-1} + b_h) over T steps, one shared memory.
// Define RNN_RELU_EN for a clipped-ReLU activation instead of hardtanh.
module rnn_cell_param #(
  parameter int HID  = 64,
  parameter int IN_W = 32,
  parameter int DW   = 20,
  parameter int FRAC = 16,
  parameter int AW   = 17,
  parameter int TW   = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          i_en,
  input  logic [31:0]   idata,
  output logic          mce,
  output logic [2:0]    msel,
  output logic [AW-1:0] maddr,
  input  logic [DW-1:0] mdata_r,
  output logic [DW-1:0] mdata_w
);
  localparam int HB   = $clog2(HID);
  localparam int XB   = $clog2(IN_W);
  localparam int KW   = (HB > 5) ? HB : 5;
  localparam int ACCW = 2*DW + $clog2(IN_W + HID + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HDR_RD, S_LDX, S_BX, S_WX, S_UH, S_BH, S_ACT, S_WR, S_DONE
  } state_t;
  // Tags what the read data arriving this cycle belongs to (reads return one cycle late).
  typedef enum logic [2:0] {P_NONE, P_BX, P_W, P_U, P_BH} pend_t;

  state_t               state;
  pend_t                pend;
  logic [KW-1:0]        k, pend_k, k_nxt;
  logic [HB-1:0]        j;
  logic [TW-1:0]        t, t_max;
  logic [31:0]          x_reg;
  logic [DW-1:0]        h_old [HID];
  logic [DW-1:0]        h_new [HID];
  logic signed [ACCW-1:0]   acc, rd_ext, prod_ext, term, acc_sum, rnd, pos_lim, lo_lim;
  logic signed [2*DW-1:0]   a_ext, b_ext, prod;
  logic [DW-1:0]        act_val;
  logic [AW-1:0]        w_first, u_first, w_next, u_next;

  assign mce = busy;

  always_comb begin
    k_nxt   = k + KW'(1);
    w_first = AW'(j) << XB;
    u_first = AW'(j) << HB;
    w_next  = w_first | AW'(k_nxt);
    u_next  = u_first | AW'(k_nxt);
  end

  always_comb begin
    rd_ext   = {{(ACCW-DW){mdata_r[DW-1]}}, mdata_r} <<< FRAC;
    a_ext    = {{DW{mdata_r[DW-1]}}, mdata_r};
    b_ext    = {{DW{h_old[pend_k[HB-1:0]][DW-1]}}, h_old[pend_k[HB-1:0]]};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    term     = '0;
    case (pend)
      P_BX, P_BH: term = rd_ext;
      P_W:        if (x_reg[pend_k[4:0]]) term = rd_ext;
      P_U:        term = prod_ext;
      default:    term = '0;
    endcase
    acc_sum = acc + term;
    pos_lim = '0;
    pos_lim[FRAC] = 1'b1;
`ifdef RNN_RELU_EN
    lo_lim = '0;
`else
    lo_lim = -pos_lim;
`endif
    // Round half toward +inf, then clamp in the Q-format of the state.
    rnd = (acc_sum + (pos_lim >>> 1)) >>> FRAC;
    if (rnd > pos_lim)     act_val = pos_lim[DW-1:0];
    else if (rnd < lo_lim) act_val = lo_lim[DW-1:0];
    else                   act_val = rnd[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      i_en    <= 1'b0;
      msel    <= '0;
      maddr   <= '0;
      mdata_w <= '0;
      k       <= '0;
      j       <= '0;
      t       <= '0;
      t_max   <= '0;
      x_reg   <= '0;
      acc     <= '0;
      pend    <= P_NONE;
      pend_k  <= '0;
      h_old   <= '{default: '0};
      h_new   <= '{default: '0};
    end else begin
      i_en   <= 1'b0;
      msel   <= '0;
      maddr  <= '0;
      pend   <= P_NONE;
      pend_k <= k;
      if (state == S_BX) acc <= '0;
      else if (pend != P_NONE) acc <= acc_sum;
      case (state)
        S_IDLE: if (ready) begin
          state <= S_HDR;
          busy  <= 1'b1;
          msel  <= 3'b100;
        end
        S_HDR: state <= S_HDR_RD;
        S_HDR_RD: begin
          t_max <= mdata_r[TW-1:0];
          t     <= '0;
          if (mdata_r[TW-1:0] == '0) state <= S_DONE;
          else begin
            state <= S_LDX;
            i_en  <= 1'b1;
          end
        end
        S_LDX: begin
          x_reg <= idata;
          j     <= '0;
          state <= S_BX;
          msel  <= 3'b001;
        end
        S_BX: begin
          pend  <= P_BX;
          k     <= '0;
          state <= S_WX;
          msel  <= 3'b000;
          maddr <= w_first;
        end
        S_WX: begin
          pend <= P_W;
          if (k != KW'(IN_W-1)) begin
            k     <= k_nxt;
            msel  <= 3'b000;
            maddr <= w_next;
          end else if (t != '0) begin
            k     <= '0;
            state <= S_UH;
            msel  <= 3'b010;
            maddr <= u_first;
          end else begin
            state <= S_BH;
            msel  <= 3'b011;
            maddr <= AW'(j);
          end
        end
        S_UH: begin
          pend <= P_U;
          if (k != KW'(HID-1)) begin
            k     <= k_nxt;
            msel  <= 3'b010;
            maddr <= u_next;
          end else begin
            state <= S_BH;
            msel  <= 3'b011;
            maddr <= AW'(j);
          end
        end
        S_BH: begin
          pend  <= P_BH;
          state <= S_ACT;
        end
        S_ACT: begin
          h_new[j] <= act_val;
          mdata_w  <= act_val;
          state    <= S_WR;
          msel     <= 3'b101;
          maddr    <= AW'({t, j});
        end
        S_WR: begin
          if (j != HB'(HID-1)) begin
            j     <= j + HB'(1);
            state <= S_BX;
            msel  <= 3'b001;
            maddr <= AW'(j + HB'(1));
          end else begin
            h_old <= h_new;
            if (t != t_max - TW'(1)) begin
              t     <= t + TW'(1);
              state <= S_LDX;
              i_en  <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_cell_param.sv
// Bench for rnn_cell_param (HID=4, IN_W=4): table of runs, write scoreboard, abort-by-reset sequence.
module tb_rnn_cell_param;
  localparam int HID = 4, IN_W = 4, DW = 20, FRAC = 16, AW = 17, TW = 20;
`ifdef RNN_RELU_EN
  localparam logic [DW-1:0] NEG_SAT = 20'h00000, NEG_HALF = 20'h00000;
  localparam logic [DW-1:0] NEG_ONE = 20'h00000, NEG_TWO  = 20'h00000;
`else
  localparam logic [DW-1:0] NEG_SAT = 20'hF0000, NEG_HALF = 20'hF8000;
  localparam logic [DW-1:0] NEG_ONE = 20'hFFFFF, NEG_TWO  = 20'hFFFFE;
`endif

  logic clk = 1'b0;
  logic reset, ready;
  logic [31:0] idata = '0;
  logic busy, i_en, mce;
  logic [2:0] msel;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_r = '0, mdata_w;

  always #5 clk = ~clk;

  rnn_cell_param #(.HID(HID), .IN_W(IN_W), .DW(DW), .FRAC(FRAC), .AW(AW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .i_en(i_en), .idata(idata),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_r(mdata_r), .mdata_w(mdata_w)
  );

  typedef struct {
    int                   T;
    logic [3:0]           x0, x1;
    logic [DW-1:0]        w, bx, bh;
    logic [3:0][DW-1:0]   u, e0, e1;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  vec_t          vt[9];
  int            hdr_t;
  logic [DW-1:0] w_mem[16], u_mem[16], bx_mem[4], bh_mem[4];
  logic [3:0]    xs[4];
  int            xi, inen_cnt;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Synchronous memory: data for the address seen this cycle appears next cycle.
  always @(posedge clk) begin
    case (msel)
      3'b100:  mdata_r <= DW'(hdr_t);
      3'b000:  mdata_r <= w_mem[maddr[3:0]];
      3'b001:  mdata_r <= bx_mem[maddr[1:0]];
      3'b010:  mdata_r <= u_mem[maddr[3:0]];
      3'b011:  mdata_r <= bh_mem[maddr[1:0]];
      default: mdata_r <= '0;
    endcase
  end

  always @(negedge clk) begin
    if (i_en) begin
      idata = {28'hFFFFFFF, xs[xi]};
      if (xi < 3) xi++;
      inen_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mce && msel == 3'b101) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", maddr, mdata_w);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(maddr), 32'(e.addr));
        chk("wr_data", 32'(mdata_w), 32'(e.data));
      end
    end
  end

  function automatic vec_t mk(input int T, input logic [3:0] x0, input logic [3:0] x1,
                              input logic [DW-1:0] w, input logic [DW-1:0] bx,
                              input logic [DW-1:0] bh, input logic [DW-1:0] ud,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    vec_t r;
    r.T = T; r.x0 = x0; r.x1 = x1; r.w = w; r.bx = bx; r.bh = bh;
    for (int j = 0; j < 4; j++) begin
      r.u[j] = ud; r.e0[j] = e0; r.e1[j] = e1;
    end
    return r;
  endfunction

  task automatic load(input vec_t v);
    hdr_t = v.T;
    for (int i = 0; i < 16; i++) begin
      w_mem[i] = v.w;
      u_mem[i] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      bx_mem[j] = v.bx;
      bh_mem[j] = v.bh;
      u_mem[j*5] = v.u[j];
    end
    xs[0] = v.x0; xs[1] = v.x1; xs[2] = 4'h0; xs[3] = 4'h0;
    xi = 0;
    inen_cnt = 0;
  endtask

  task automatic start_run(input int id);
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    chk($sformatf("v%0d_start_busy", id), 32'(busy), 1);
    chk($sformatf("v%0d_hdr_msel", id), 32'(msel), 32'(3'b100));
    chk($sformatf("v%0d_hdr_maddr", id), 32'(maddr), 0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc, exp_cyc;
    bit done;
    load(v);
    for (int t = 0; t < v.T; t++)
      for (int j = 0; j < 4; j++)
        sb.push_back('{addr: AW'(t*4 + j), data: (t == 0) ? v.e0[j] : v.e1[j]});
    exp_cyc = 3 + v.T + v.T*HID*(4 + IN_W) + ((v.T > 0) ? (v.T - 1)*HID*HID : 0);
    start_run(id);
    cyc = 1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (busy && cyc < 5000) cyc++;
      else done = 1'b1;
    end
    chk($sformatf("v%0d_busy_cycles", id), 32'(cyc), 32'(exp_cyc));
    chk($sformatf("v%0d_ien_pulses", id), 32'(inen_cnt), 32'(v.T));
    chk($sformatf("v%0d_writes_left", id), 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    vec_t v;
    bit found;
    vt[0] = mk(1, 4'b0101, 4'b0000, 20'h01000, 20'h0, 20'h0, 20'h0, 20'h02000, 20'h0);
    vt[1] = mk(2, 4'b0101, 4'b0000, 20'h01000, 20'h0, 20'h0, 20'h10000, 20'h02000, 20'h02000);
    vt[2] = mk(1, 4'b0000, 4'b0000, 20'h0, 20'h30000, 20'h0, 20'h0, 20'h10000, 20'h0);
    vt[3] = mk(1, 4'b0000, 4'b0000, 20'h0, 20'hD0000, 20'h0, 20'h0, NEG_SAT, 20'h0);
    vt[4] = mk(2, 4'b0001, 4'b0000, 20'h00001, 20'h0, 20'h0, 20'h0, 20'h00001, 20'h0);
    vt[4].u[0] = 20'h18000; vt[4].e1[0] = 20'h00002;
    vt[4].u[1] = 20'hE8000; vt[4].e1[1] = NEG_ONE;
    vt[4].u[2] = 20'hE6666; vt[4].e1[2] = NEG_TWO;
    vt[4].u[3] = 20'h10000; vt[4].e1[3] = 20'h00001;
    vt[5] = mk(1, 4'b1111, 4'b0000, 20'h02000, 20'h08000, 20'hFC000, 20'h0, 20'h0C000, 20'h0);
    vt[6] = mk(1, 4'b1010, 4'b0000, 20'hFC000, 20'h0, 20'h0, 20'h0, NEG_HALF, 20'h0);
    vt[7] = mk(0, 4'b0000, 4'b0000, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0);
    vt[8] = vt[0];

    reset = 1'b0;
    ready = 1'b0;
    load(vt[0]);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ien", 32'(i_en), 0);
    chk("rst_mce", 32'(mce), 0);
    chk("rst_msel", 32'(msel), 0);
    chk("rst_maddr", 32'(maddr), 0);
    chk("rst_mdata_w", 32'(mdata_w), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Abort a T=3 run in the middle of the first U phase.
    v = vt[0];
    v.T = 3;
    load(v);
    for (int j = 0; j < 4; j++) sb.push_back('{addr: AW'(j), data: v.e0[j]});
    start_run(100);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (msel == 3'b010) found = 1'b1;
    end
    chk("abort_uh_reached", 32'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ien", 32'(i_en), 0);
    chk("abort_mce", 32'(mce), 0);
    chk("abort_msel", 32'(msel), 0);
    chk("abort_maddr", 32'(maddr), 0);
    chk("abort_mdata_w", 32'(mdata_w), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_writes_left", 32'(sb.size()), 0);
    sb.delete();

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
